spi16_master: RTL

- 16-bit SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
- Complements the baseboard's existing 16-bit SPI slave: the FPGA initiates transfers to on-board SPI devices (e.g. ADC on the adapter board).
- Core logic presents one word plus a start strobe and receives the full-duplex response word with a done pulse.
- Programmable SCLK rate, chip-select setup/hold and inter-word gap.

---
 rtl/spi16_master.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/spi16_master.sv
// 16-bit SPI master, mode 0 (CPOL=0, CPHA=0), MSB first, full duplex.
// The core presents one word with a start strobe. It gets back the received word
// together with a one-cycle done pulse. SCLK rate, chip-select setup/hold and the
// inter-word gap are set by parameters.
//
// Ports:
//   clk    system clock
//   res_n  asynchronous active-low reset
//   start  transfer request, sampled only while idle
//   din    word to transmit, captured when start is accepted
//   busy   high from start acceptance until the end of the gap
//   done   one-cycle pulse; dout is valid from this cycle on
//   dout   received word, held until the next done
//   nSS    chip select, active low
//   SCLK   serial clock, idles low
//   MOSI   serial data out
//   MISO   serial data in
// All outputs are driven directly from registers.

module spi16_master #(
  parameter int unsigned CLKDIV    = 4,  // SCLK half-period in clk cycles, 1..65535
  parameter int unsigned SETUP_CYC = 2,  // nSS fall to first SCLK rise, 1..255
  parameter int unsigned HOLD_CYC  = 2,  // last SCLK fall to nSS rise, 1..255
  parameter int unsigned GAP_CYC   = 2   // nSS high before busy drops, 0..255
) (
  input  logic        clk,
  input  logic        res_n,
  input  logic        start,
  input  logic [15:0] din,
  output logic        busy,
  output logic        done,
  output logic [15:0] dout,
  output logic        nSS,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  typedef enum logic [2:0] {
    StIdle,
    StSetup,
    StShiftHi,
    StShiftLo,
    StHold,
    StGap
  } state_e;

  // Counters are loaded with (cycles - 1) and the phase ends on the cycle they read zero.
  localparam logic [15:0] DivLoad   = 16'(CLKDIV - 1);
  localparam logic [15:0] SetupLoad = 16'(SETUP_CYC - 1);
  localparam logic [15:0] HoldLoad  = 16'(HOLD_CYC - 1);
  localparam logic [15:0] GapLoad   = (GAP_CYC == 0) ? 16'd0 : 16'(GAP_CYC - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] tx_q, tx_d;
  logic [15:0] rx_q, rx_d;
  logic [15:0] dout_q, dout_d;
  logic        sclk_q, sclk_d;
  logic        nss_q, nss_d;
  logic        mosi_q, mosi_d;
  logic        busy_q, busy_d;
  logic        done_q, done_d;

  logic cnt_zero;
  logic last_bit;

  assign cnt_zero = (cnt_q == 16'd0);
  assign last_bit = (bit_q == 4'hF);

  // State and registered outputs
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      state_q <= StIdle;
      cnt_q   <= 16'd0;
      bit_q   <= 4'd0;
      tx_q    <= 16'd0;
      rx_q    <= 16'd0;
      dout_q  <= 16'd0;
      sclk_q  <= 1'b0;
      nss_q   <= 1'b1;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      dout_q  <= dout_d;
      sclk_q  <= sclk_d;
      nss_q   <= nss_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state, phase counter and bit counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StSetup;
          cnt_d   = SetupLoad;
          bit_d   = 4'd0;
        end
      end
      StSetup: begin
        if (cnt_zero) begin
          state_d = StShiftHi;
          cnt_d   = DivLoad;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StShiftHi: begin
        if (cnt_zero) begin
          if (last_bit) begin
            state_d = StHold;
            cnt_d   = HoldLoad;
          end else begin
            state_d = StShiftLo;
            cnt_d   = DivLoad;
            bit_d   = bit_q + 4'd1;
          end
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StShiftLo: begin
        if (cnt_zero) begin
          state_d = StShiftHi;
          cnt_d   = DivLoad;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StHold: begin
        if (cnt_zero) begin
          // With no gap the FSM returns straight to idle on the done edge.
          state_d = (GAP_CYC == 0) ? StIdle : StGap;
          cnt_d   = GapLoad;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      StGap: begin
        if (cnt_zero) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 16'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Next values of the shift registers and the pin/handshake registers
  always_comb begin
    tx_d   = tx_q;
    rx_d   = rx_q;
    dout_d = dout_q;
    sclk_d = sclk_q;
    nss_d  = nss_q;
    mosi_d = mosi_q;
    busy_d = busy_q;
    done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          tx_d   = din;
          mosi_d = din[15];
          nss_d  = 1'b0;
          busy_d = 1'b1;
        end
      end
      StSetup, StShiftLo: begin
        if (cnt_zero) begin
          sclk_d = 1'b1;
          rx_d   = {rx_q[14:0], MISO};
        end
      end
      StShiftHi: begin
        if (cnt_zero) begin
          sclk_d = 1'b0;
          // After the last falling edge MOSI keeps bit 0 through the hold phase.
          if (!last_bit) begin
            tx_d   = {tx_q[14:0], 1'b0};
            mosi_d = tx_q[14];
          end
        end
      end
      StHold: begin
        if (cnt_zero) begin
          nss_d  = 1'b1;
          mosi_d = 1'b0;
          dout_d = rx_q;
          done_d = 1'b1;
          if (GAP_CYC == 0) begin
            busy_d = 1'b0;
          end
        end
      end
      StGap: begin
        if (cnt_zero) begin
          busy_d = 1'b0;
        end
      end
      default: ;
    endcase
  end

  assign busy = busy_q;
  assign done = done_q;
  assign dout = dout_q;
  assign nSS  = nss_q;
  assign SCLK = sclk_q;
  assign MOSI = mosi_q;

endmodule
